// File: rtl/pipeline_scoreboard.sv
// rtl/pipeline_scoreboard.sv - ID hazard scoreboard with stall, flush and EX forward selects
// Optional EX forwarding is enabled by defining PSB_FORWARD_EN; otherwise every in-flight match stalls.
module pipeline_scoreboard #(
    parameter int REG_AW     = 3,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16,
    localparam int FW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [REG_AW-1:0] id_rs,
    input  logic              id_rd_rd,
    input  logic              id_rs_rd,
    input  logic              id_we,
    input  logic              id_load,
    input  logic              flush,
    output logic              stall,
    output logic [FW-1:0]     ex_fwd_rd,
    output logic [FW-1:0]     ex_fwd_rs,
    output logic [CNT_W-1:0]  stall_count
);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  load_q, load_d;
    logic [REG_AW-1:0] tag_rd_q [DEPTH];
    logic [REG_AW-1:0] tag_rd_d [DEPTH];
    logic [FW-1:0]     fwd_rd_q, fwd_rd_d;
    logic [FW-1:0]     fwd_rs_q, fwd_rs_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              rd_hit, rs_hit;
    logic              rd_ld, rs_ld;
    logic              rd_ok, rs_ok;
    logic [FW-1:0]     rd_sel, rs_sel;
    logic              haz_rd, haz_rs;
    logic              issue;

    // Scan oldest to youngest so the lowest matching stage is the one left standing.
    // The WB stage is skipped: the register file writes through to the read port.
    always_comb begin
        rd_hit = 1'b0;
        rd_sel = '0;
        rd_ld  = 1'b0;
        rs_hit = 1'b0;
        rs_sel = '0;
        rs_ld  = 1'b0;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            if (id_rd_rd && valid_q[k] && (tag_rd_q[k] == id_rd)) begin
                rd_hit = 1'b1;
                rd_sel = FW'(k + 1);
                rd_ld  = load_q[k];
            end
            if (id_rs_rd && valid_q[k] && (tag_rd_q[k] == id_rs)) begin
                rs_hit = 1'b1;
                rs_sel = FW'(k + 1);
                rs_ld  = load_q[k];
            end
        end
        rd_ok = ~rd_ld | (int'(rd_sel) >= LOAD_READY);
        rs_ok = ~rs_ld | (int'(rs_sel) >= LOAD_READY);
    end

`ifdef PSB_FORWARD_EN
    assign haz_rd   = rd_hit & ~rd_ok;
    assign haz_rs   = rs_hit & ~rs_ok;
    assign fwd_rd_d = (issue && rd_hit) ? rd_sel : '0;
    assign fwd_rs_d = (issue && rs_hit) ? rs_sel : '0;
`else
    logic unused_fwd;
    assign haz_rd     = rd_hit;
    assign haz_rs     = rs_hit;
    assign fwd_rd_d   = '0;
    assign fwd_rs_d   = '0;
    assign unused_fwd = ^{rd_sel, rs_sel, rd_ok, rs_ok};
`endif

    assign stall = id_valid & (haz_rd | haz_rs) & ~flush;
    assign issue = id_valid & ~stall & ~flush;

    // A flush from MEM also kills the instruction currently in EX as it moves on.
    always_comb begin
        valid_d     = {valid_q[DEPTH-2:0], issue & id_we};
        valid_d[1]  = valid_q[0] & ~flush;
        load_d      = {load_q[DEPTH-2:0], id_load};
        tag_rd_d[0] = id_rd;
        for (int k = 1; k < DEPTH; k++) begin
            tag_rd_d[k] = tag_rd_q[k-1];
        end
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= '0;
            load_q   <= '0;
            fwd_rd_q <= '0;
            fwd_rs_q <= '0;
            cnt_q    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tag_rd_q[k] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            load_q   <= load_d;
            fwd_rd_q <= fwd_rd_d;
            fwd_rs_q <= fwd_rs_d;
            cnt_q    <= cnt_d;
            for (int k = 0; k < DEPTH; k++) begin
                tag_rd_q[k] <= tag_rd_d[k];
            end
        end
    end

    assign ex_fwd_rd   = fwd_rd_q;
    assign ex_fwd_rs   = fwd_rs_q;
    assign stall_count = cnt_q;

endmodule
